spi_bus_scheduler: RTL
======================

# spi_bus_scheduler

Shares one byte-level SPI master engine among N_REQ requesters. Grants whole multi-byte transactions round-robin, drives a per-requester active-low chip select with programmable setup/hold/gap guard times, and sequences the engine one byte at a time over a start/done handshake. It sits between the client blocks (flash, ADC, config ports) and the single SPI driver instance on the board bus.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- CS_SETUP, 2: clk cycles from cs_n fall to first byte offer, ≥1.
- CS_HOLD, 2: clk cycles from last eng_done to cs_n rise, ≥1.
- CS_GAP, 1: minimum clk cycles with all cs_n high between transactions, ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  N_REQ  requester i has a TX byte.
- req_data  in  8*N_REQ  TX byte of requester i, bits [8i+7:8i].
- req_last  in  N_REQ  byte is the final one of the transaction.
- req_ready  out  N_REQ  byte accepted; at most one bit high.
- rsp_valid  out  1  one-cycle pulse, RX byte available.
- rsp_data  out  8  RX byte.
- rsp_id  out  $clog2(N_REQ)  owner of rsp_data.
- rsp_last  out  1  RX byte belongs to the last TX byte.
- cs_n  out  N_REQ  chip selects, active low.
- eng_start  out  1  one-cycle pulse, launch byte.
- eng_tx  out  8  byte to engine, stable from eng_start until eng_done.
- eng_done  in  1  one-cycle pulse, byte complete.
- eng_rx  in  8  received byte, valid with eng_done.
- proto_err  out  1  sticky: eng_done seen outside WAIT.

## Operation
- FSM states: IDLE, SETUP, SEND, WAIT, HOLD, GAP.
- IDLE: if any req_valid is high, pick the first requester at or after (last_grant+1) mod N_REQ. Register grant g and last_grant. Go to SETUP.
- SETUP: cs_n[g]=0. Count CS_SETUP cycles, then go to SEND.
- SEND: req_ready[g] = req_valid[g], combinational. On handshake, capture the byte and last flag, then go to WAIT. If req_valid[g]=0, stay in SEND with cs_n held low; there is no timeout.
- WAIT: eng_start=1 in the first WAIT cycle only. On eng_done, rsp_valid=1 for one cycle with rsp_data=eng_rx, rsp_id=g and rsp_last=captured last. Then go to HOLD if last, else to SEND.
- HOLD: cs_n[g] stays low for CS_HOLD cycles, then go to GAP.
- GAP: all cs_n high for CS_GAP cycles, then go to IDLE.
- req_valid of non-granted requesters is ignored until IDLE. There is no preemption.
- An eng_done in the same cycle as eng_start is invalid and sets proto_err. An eng_done in any state other than WAIT sets proto_err and is otherwise ignored.
- Reset values:
  - all cs_n=1; req_ready=0; eng_start=0; eng_tx=0.
  - rsp_valid=0; rsp_data=0; rsp_id=0; rsp_last=0; proto_err=0.
  - state IDLE; last_grant=N_REQ-1, so requester 0 wins first.
- Reset mid-transaction: cs_n goes high asynchronously. The engine shares rst.

## Timing
- Cycle T: IDLE sees request. T+1: cs_n[g] low, SETUP. T+1+CS_SETUP: SEND, req_ready high if valid. T+2+CS_SETUP: eng_start.
- eng_done at cycle D gives rsp_valid at D+1.
  - Non-last byte: next req_ready at D+1, eng_start at D+2 if valid.
  - Last byte: cs_n[g] rises at D+1+CS_HOLD. The next grant's cs_n falls no earlier than D+2+CS_HOLD+CS_GAP.
- All outputs are registered except req_ready.
- Counter width is $clog2(max(CS_SETUP,CS_HOLD,CS_GAP)+1). Counters load on state entry and exit at terminal count 1.

## Structure
- Package spi_sched_pkg: state enum sched_state_t, default guard constants, a grant-index width function.
- Sub-module spi_rr_arbiter: N_REQ-wide round-robin picker. Inputs are the request vector and last_grant; outputs are the one-hot grant, the index, and any_req. It is combinational and holds no pointer, which stays in the FSM.

## Test plan
- Single transaction, requester 2, bytes A5,3C (last). Engine echoes inverted bytes after 16 cycles. Required: cs_n[2] low for exactly 2+two transfers+2 cycles; rsp 5A then C3 with rsp_id=2 and rsp_last on the second.
- All four requesters request after reset, one byte each. Required grant order 0,1,2,3, at least CS_GAP all-high cycles between transactions, never two cs_n low at once.
- Requester 1 drops req_valid for 10 cycles mid-transaction. Required: cs_n[1] stays low, no eng_start, requester 0 is not granted, resume completes normally.
- Requesters 0 and 3 request repeatedly after last_grant=0. Required alternation 3,0,3,0.
- rst asserted in WAIT. Required: cs_n all high in the same cycle (async), rsp_valid=0, first grant after release goes to requester 0.
- eng_done pulsed in IDLE, or in the same cycle as eng_start. Required: proto_err=1 sticky, FSM unaffected.

Source files
------------

// File: rtl/spi_sched_pkg.sv
// Shared types and sizing helpers for the SPI bus scheduler slice.
// Holds the scheduler state encoding and default chip-select guard times.
package spi_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SEND,
      WAIT,
      HOLD,
      GAP
   } sched_state_t;

   localparam int DEF_CS_SETUP = 2;
   localparam int DEF_CS_HOLD  = 2;
   localparam int DEF_CS_GAP   = 1;

   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Guard counters must hold the largest of the three guard times.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after last_grant+1.
// The rotating pointer lives in the caller, so this block holds no state.
module spi_rr_arbiter
   import spi_sched_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int IW    = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    last_grant,
   output logic [N_REQ-1:0] grant,
   output logic [IW-1:0]    grant_idx,
   output logic             any_req
);

   logic found;
   int   cand;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_req   = |req;
      found     = 1'b0;
      cand      = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = (int'(last_grant) + k) % N_REQ;
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/spi_bus_scheduler.sv
// Shares one byte-level SPI engine among N_REQ requesters, granting whole
// transactions round-robin with per-requester chip select and guard times.
module spi_bus_scheduler
   import spi_sched_pkg::*;
#(
   parameter  int N_REQ    = 4,
   parameter  int CS_SETUP = DEF_CS_SETUP,
   parameter  int CS_HOLD  = DEF_CS_HOLD,
   parameter  int CS_GAP   = DEF_CS_GAP,
   localparam int IW       = idx_width(N_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_data,
   input  logic [N_REQ-1:0]     req_last,
   output logic [N_REQ-1:0]     req_ready,
   output logic                 rsp_valid,
   output logic [7:0]           rsp_data,
   output logic [IW-1:0]        rsp_id,
   output logic                 rsp_last,
   output logic [N_REQ-1:0]     cs_n,
   output logic                 eng_start,
   output logic [7:0]           eng_tx,
   input  logic                 eng_done,
   input  logic [7:0]           eng_rx,
   output logic                 proto_err
);

   localparam int CW = cnt_width(CS_SETUP, CS_HOLD, CS_GAP);
   localparam logic [CW-1:0] SETUP_LD = CW'(CS_SETUP);
   localparam logic [CW-1:0] HOLD_LD  = CW'(CS_HOLD);
   localparam logic [CW-1:0] GAP_LD   = CW'(CS_GAP);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   sched_state_t       state;
   logic [IW-1:0]      grant;
   logic [IW-1:0]      last_grant;
   logic [CW-1:0]      cnt;
   logic               last_q;

   logic [N_REQ-1:0]   arb_grant;
   logic [IW-1:0]      arb_idx;
   logic               arb_any;

   spi_rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_arb (
      .req        (req_valid),
      .last_grant (last_grant),
      .grant      (arb_grant),
      .grant_idx  (arb_idx),
      .any_req    (arb_any)
   );

   // Only the owner of the bus can see ready, and only while a byte slot is open.
   always_comb begin
      req_ready = '0;
      if (state == SEND) req_ready[grant] = req_valid[grant];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= IW'(N_REQ - 1);
         cnt        <= '0;
         last_q     <= 1'b0;
         cs_n       <= '1;
         eng_start  <= 1'b0;
         eng_tx     <= '0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_id     <= '0;
         rsp_last   <= 1'b0;
         proto_err  <= 1'b0;
      end else begin
         eng_start <= 1'b0;
         rsp_valid <= 1'b0;

         // A completion is only legal while a launched byte is outstanding.
         if (eng_done && (state != WAIT || eng_start)) proto_err <= 1'b1;

         case (state)
            IDLE: begin
               if (arb_any) begin
                  grant      <= arb_idx;
                  last_grant <= arb_idx;
                  cs_n       <= ~arb_grant;
                  cnt        <= SETUP_LD;
                  state      <= SETUP;
               end
            end
            SETUP: begin
               if (cnt == CNT_ONE) state <= SEND;
               else                cnt   <= cnt - 1'b1;
            end
            SEND: begin
               if (req_valid[grant]) begin
                  eng_tx    <= req_data[8*grant +: 8];
                  last_q    <= req_last[grant];
                  eng_start <= 1'b1;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (eng_done && !eng_start) begin
                  rsp_valid <= 1'b1;
                  rsp_data  <= eng_rx;
                  rsp_id    <= grant;
                  rsp_last  <= last_q;
                  if (last_q) begin
                     cnt   <= HOLD_LD;
                     state <= HOLD;
                  end else begin
                     state <= SEND;
                  end
               end
            end
            HOLD: begin
               if (cnt == CNT_ONE) begin
                  cs_n  <= '1;
                  cnt   <= GAP_LD;
                  state <= GAP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            GAP: begin
               if (cnt == CNT_ONE) state <= IDLE;
               else                cnt   <= cnt - 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
